data_store_buffer: RTL and testbench
====================================

Name: data_store_buffer

Overview:
- Posted-write buffer between the core's data-memory port (ram_* bus) and data_ram, for a data memory whose writes need WR_CYCLES cycles.
- Stores are queued and the core continues; entries drain to memory in order when the memory port is free.
- Loads get youngest-first byte forwarding from queued stores, then memory for uncovered bytes.
- Raises stallreq to the core's stall controller when the buffer is full or when a load needs memory during a drain.

Parameters:
- DEPTH, 4, number of buffered store entries (power of two, ≥2).
- WR_CYCLES, 2, cycles mem_ce/mem_we are held per drained write (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_ce  input  1  core data access valid
- cpu_we  input  1  1=store, 0=load
- cpu_addr  input  32  byte address; word index = cpu_addr[31:2]
- cpu_sel  input  4  byte enables
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data (combinational)
- stallreq  output  1  core must hold the current request
- mem_ce  output  1  data_ram enable
- mem_we  output  1  data_ram write
- mem_addr  output  32  data_ram address (word aligned, [1:0]=0)
- mem_sel  output  4  data_ram byte enables
- mem_wdata  output  32  data_ram write data
- mem_rdata  input  32  data_ram combinational read data

Behaviour:
- Entry: {word_addr[29:0], sel[3:0], data[31:0]}. Circular FIFO with head/tail pointers (wrap mod DEPTH) and count 0..DEPTH.
- Reset (rst=0, async): count=0, pointers=0, drain FSM in IDLE, cnt=0. All outputs are 0 while rst=0. Queued stores are discarded.
- Drain FSM, IDLE:
  - Drain starts when the buffer is non-empty and there is no load (load = cpu_ce & !cpu_we).
  - That cycle is write cycle 1: mem_ce=mem_we=1, mem_addr={head.addr,2'b00}, mem_sel/mem_wdata from head.
  - If WR_CYCLES=1, head pops at this edge and the FSM stays IDLE. Otherwise go to BUSY with cnt=1.
- Drain FSM, BUSY:
  - Keep driving the head write.
  - When cnt==WR_CYCLES-1, pop head at this edge and return to IDLE. Otherwise cnt++.
  - The next drain may start in the following IDLE cycle (back-to-back).
- Memory port, IDLE with a load: mem_ce=1, mem_we=0, mem_addr={cpu_addr[31:2],2'b00}, mem_sel=cpu_sel. The load has priority and the drain is deferred.
- Memory port, otherwise idle: all mem_* = 0.
- Load forwarding:
  - For each byte b, take the youngest valid entry with matching word_addr and sel[b]=1. If none, take mem_rdata byte b.
  - Zero latency; cpu_rdata is valid in the request cycle.
  - Bytes with cpu_sel[b]=0 read 0.
  - The head entry being drained still counts for forwarding until it pops.
- Load during BUSY:
  - If every byte with cpu_sel=1 is covered by the buffer: cpu_rdata returned, stallreq=0.
  - Otherwise stallreq=1 and cpu_rdata is don't-care. The load is served in the first IDLE cycle.
- Store (cpu_ce & cpu_we):
  - Enqueue at tail at the clock edge if count<DEPTH, or if count==DEPTH and a pop occurs this same edge. In both cases stallreq=0.
  - If full with no pop this cycle: stallreq=1, no enqueue.
  - Simultaneous enqueue and pop leaves count unchanged.
  - No coalescing: same-address stores occupy separate entries and drain in program order.
- stallreq is combinational from current state and the cpu_* inputs. cpu_ce=0 implies stallreq=0.
- cpu_sel=0 store: enqueued and drained normally (memory is unchanged).

Decomposition:
- defines.v additions:
  - SbDepth=4, SbWrCycles=2
  - `SbEntryBus width 66
  - `SbIdle/`SbBusy state encodings
- One sub-module, data_sb_fwd_merge: combinational. Inputs are the entry array, valid mask, age order from head, load address/sel and mem_rdata. Outputs are merged data and a full-cover flag.
- data_store_buffer holds the FIFO, the drain FSM and stall logic.

Test Plan:
- Store/drain timing: reset, store 0x11223344 sel=1111 to 0x100, then idle. stallreq=0; mem_we=1 with addr 0x100 for exactly 2 cycles; count 1→0. A later load from 0x100 sees memory 0x11223344.
- Partial forwarding: mem[0x200]=0xAAAAAAAA. Store 0x000000BB sel=0001 to 0x200, then load 0x200 sel=1111 while BUSY. Partial cover gives stallreq=1 until IDLE, then cpu_rdata=0xAAAAAABB.
- Youngest-wins: store 0x01 sel=0001, then 0x02 sel=0001, both to 0x300. A load sel=0001 in the next cycle gives cpu_rdata[7:0]=0x02 with stallreq=0 (full cover). Memory ends at 0x02.
- Full buffer: 5 back-to-back stores with no loads. The enqueue coinciding with a pop proceeds without stall. Hold loads to fill 4 entries; the next store gives stallreq=1 until a pop; order is preserved at mem.
- Load priority in IDLE: buffer holds 2 entries, then 3 consecutive loads to other addresses. No mem_we during the loads; each load gets mem_rdata with stallreq=0. Draining resumes on the first non-load cycle.
- Reset mid-drain: drop rst in cycle 1 of BUSY. All outputs go to 0 immediately and count=0. After release, no write from the old entries appears on mem_*.

Source files
------------

// File: rtl/data_store_buffer_pkg.sv
// Shared types and defaults for the posted-write data store buffer.
// Entries hold a word address, byte enables and data for one queued store.
package data_store_buffer_pkg;

   localparam int SB_DEPTH     = 4;
   localparam int SB_WR_CYCLES = 2;
   localparam int SB_ENTRY_W   = 66;

   typedef struct packed {
      logic [29:0] word_addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } sb_entry_t;

   typedef enum logic {
      SB_IDLE = 1'b0,
      SB_BUSY = 1'b1
   } sb_state_e;

   function automatic logic [31:0] sel_mask(input logic [3:0] sel);
      sel_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/data_sb_fwd_merge.sv
// Byte-wise load forwarding: youngest matching queued store wins per byte,
// uncovered bytes come from memory, unselected bytes read as zero.
module data_sb_fwd_merge
   import data_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input  sb_entry_t [DEPTH-1:0]      entries,
   input  logic [DEPTH-1:0]           valid,
   input  logic [$clog2(DEPTH)-1:0]   head,
   input  logic [29:0]                load_word_addr,
   input  logic [3:0]                 load_sel,
   input  logic [31:0]                mem_rdata,
   output logic [31:0]                merged_data,
   output logic                       full_cover
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      fwd_data;
   logic [3:0]       covered;
   logic [PTR_W-1:0] idx;

   // Walk from oldest to youngest so a younger matching byte overwrites an older one.
   always_comb begin
      fwd_data = '0;
      covered  = '0;
      idx      = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (valid[idx] && (entries[idx].word_addr == load_word_addr)) begin
            for (int b = 0; b < 4; b++) begin
               if (entries[idx].sel[b]) begin
                  fwd_data[8*b +: 8] = entries[idx].data[8*b +: 8];
                  covered[b]         = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      merged_data = '0;
      for (int b = 0; b < 4; b++) begin
         merged_data[8*b +: 8] = covered[b] ? fwd_data[8*b +: 8] : mem_rdata[8*b +: 8];
      end
      merged_data = merged_data & sel_mask(load_sel);
   end

   assign full_cover = &(covered | ~load_sel);

endmodule

// File: rtl/data_store_buffer.sv
// Posted-write buffer between the core data port and data_ram: queues stores,
// drains them in order over WR_CYCLES-long writes, and forwards to loads.
module data_store_buffer
   import data_store_buffer_pkg::*;
#(
   parameter int DEPTH     = SB_DEPTH,
   parameter int WR_CYCLES = SB_WR_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [3:0]  cpu_sel,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        stallreq,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

   sb_entry_t [DEPTH-1:0] entries_q, entries_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [PTR_W:0]        count_q, count_d;
   sb_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic             is_load, is_store, empty, full, pop, enq, drive_head;
   logic [DEPTH-1:0] valid_mask;
   logic [PTR_W-1:0] offset;
   sb_entry_t        head_entry;
   logic [31:0]      merged_data;
   logic             full_cover;
   logic             stall_c;
   logic             mem_ce_c, mem_we_c;
   logic [31:0]      mem_addr_c, mem_wdata_c;
   logic [3:0]       mem_sel_c;
   logic             unused_addr_bits;

   assign is_load          = cpu_ce & ~cpu_we;
   assign is_store         = cpu_ce & cpu_we;
   assign empty            = (count_q == '0);
   assign full             = (count_q == (PTR_W+1)'(DEPTH));
   assign head_entry       = entries_q[head_q];
   assign unused_addr_bits = ^cpu_addr[1:0];

   always_comb begin
      valid_mask = '0;
      offset     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset        = PTR_W'(i) - head_q;
         valid_mask[i] = ({1'b0, offset} < count_q);
      end
   end

   data_sb_fwd_merge #(
      .DEPTH(DEPTH)
   ) u_fwd_merge (
      .entries        (entries_q),
      .valid          (valid_mask),
      .head           (head_q),
      .load_word_addr (cpu_addr[31:2]),
      .load_sel       (cpu_sel),
      .mem_rdata      (mem_rdata),
      .merged_data    (merged_data),
      .full_cover     (full_cover)
   );

   // A load in IDLE owns the memory port; otherwise the head entry drains.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pop         = 1'b0;
      drive_head  = 1'b0;
      mem_ce_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_sel_c   = '0;
      mem_wdata_c = '0;
      case (state_q)
         SB_IDLE: begin
            if (is_load) begin
               mem_ce_c   = 1'b1;
               mem_addr_c = {cpu_addr[31:2], 2'b00};
               mem_sel_c  = cpu_sel;
            end else if (!empty) begin
               drive_head = 1'b1;
               if (WR_CYCLES == 1) begin
                  pop = 1'b1;
               end else begin
                  state_d = SB_BUSY;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         SB_BUSY: begin
            drive_head = 1'b1;
            if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
               pop     = 1'b1;
               state_d = SB_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = SB_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (drive_head) begin
         mem_ce_c    = 1'b1;
         mem_we_c    = 1'b1;
         mem_addr_c  = {head_entry.word_addr, 2'b00};
         mem_sel_c   = head_entry.sel;
         mem_wdata_c = head_entry.data;
      end
   end

   // A full buffer still accepts a store on the edge where the head pops.
   assign enq     = is_store & (~full | pop);
   assign stall_c = (is_store & full & ~pop) |
                    (is_load & (state_q == SB_BUSY) & ~full_cover);

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (enq) begin
         entries_d[tail_q] = '{word_addr: cpu_addr[31:2], sel: cpu_sel, data: cpu_wdata};
         tail_d            = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      case ({enq, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entries_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         state_q   <= SB_IDLE;
         cnt_q     <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

   // Outputs are combinational, so they are forced low while reset is held.
   assign cpu_rdata = (rst && is_load) ? merged_data : '0;
   assign stallreq  = rst & stall_c;
   assign mem_ce    = rst & mem_ce_c;
   assign mem_we    = rst & mem_we_c;
   assign mem_addr  = rst ? mem_addr_c  : '0;
   assign mem_sel   = rst ? mem_sel_c   : '0;
   assign mem_wdata = rst ? mem_wdata_c : '0;

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer with a small byte-enabled RAM model;
// expected values are hand-computed for DEPTH=4, WR_CYCLES=2.
module tb_data_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_sel;
   logic        stallreq;
   logic        mem_ce, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_sel;

   logic [31:0] ram [0:1023];
   bit          ram_ready = 1'b0;
   logic [63:0] wlog [$];
   int          total = 0;
   int          bad   = 0;

   data_store_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_ce    (cpu_ce),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_sel   (cpu_sel),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .stallreq  (stallreq),
      .mem_ce    (mem_ce),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_sel   (mem_sel),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr[11:2]];

   // RAM model preloads itself on the first edge, then logs every write cycle.
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
         ram[10'h080] = 32'hAAAAAAAA;
         ram_ready    = 1'b1;
      end else if (mem_ce && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_sel[b]) ram[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
         wlog.push_back({mem_addr, mem_wdata});
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [31:0] wdata);
      cpu_ce    = ce;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_sel   = sel;
      cpu_wdata = wdata;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("rst_mem_ce", 32'(mem_ce), 32'd0);
      checkOutput("rst_stall", 32'(stallreq), 32'd0);
      checkOutput("rst_rdata", cpu_rdata, 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst = 1'b1;
      nextCycle();

      // Store then drain over exactly two write cycles
      wlog.delete();
      applyStimulus(1'b1, 1'b1, 32'h100, 4'hF, 32'h11223344);
      @(negedge clk);
      checkOutput("t1_store_stall", 32'(stallreq), 32'd0);
      checkOutput("t1_store_no_we", 32'(mem_we), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("t1_wr1_we", 32'(mem_we), 32'd1);
      checkOutput("t1_wr1_addr", mem_addr, 32'h100);
      checkOutput("t1_wr1_data", mem_wdata, 32'h11223344);
      checkOutput("t1_wr1_sel", 32'(mem_sel), 32'hF);
      nextCycle();
      @(negedge clk);
      checkOutput("t1_wr2_we", 32'(mem_we), 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("t1_after_we", 32'(mem_we), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
      @(negedge clk);
      checkOutput("t1_load_data", cpu_rdata, 32'h11223344);
      checkOutput("t1_load_ce", 32'(mem_ce), 32'd1);
      checkOutput("t1_load_stall", 32'(stallreq), 32'd0);
      checkOutput("t1_log_len", 32'(wlog.size()), 32'd2);
      nextCycle();

      // Partial forwarding: load during BUSY stalls, then merges in IDLE
      applyStimulus(1'b1, 1'b1, 32'h200, 4'h1, 32'h000000BB);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("t2_drain_addr", mem_addr, 32'h200);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
      @(negedge clk);
      checkOutput("t2_busy_stall", 32'(stallreq), 32'd1);
      checkOutput("t2_busy_we", 32'(mem_we), 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("t2_idle_stall", 32'(stallreq), 32'd0);
      checkOutput("t2_idle_data", cpu_rdata, 32'hAAAAAABB);
      checkOutput("t2_idle_we", 32'(mem_we), 32'd0);
      nextCycle();

      // Youngest-wins forwarding with two stores to the same word
      wlog.delete();
      applyStimulus(1'b1, 1'b1, 32'h300, 4'h1, 32'h00000001);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h300, 4'h1, 32'h00000002);
      @(negedge clk);
      checkOutput("t3_st2_stall", 32'(stallreq), 32'd0);
      checkOutput("t3_st2_wdata", mem_wdata, 32'h00000001);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h300, 4'h1, 32'h0);
      @(negedge clk);
      checkOutput("t3_fwd_data", cpu_rdata, 32'h00000002);
      checkOutput("t3_fwd_stall", 32'(stallreq), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
      @(negedge clk);
      checkOutput("t3_mem_data", cpu_rdata, 32'h00000002);
      checkOutput("t3_log_len", 32'(wlog.size()), 32'd4);
      if (wlog.size() == 4) begin
         checkOutput("t3_log_first", wlog[0][31:0], 32'h00000001);
         checkOutput("t3_log_last", wlog[3][31:0], 32'h00000002);
      end
      nextCycle();

      // Fill the buffer with back-to-back stores; only the 8th store stalls once
      wlog.delete();
      for (int i = 0; i < 9; i++) begin
         int k;
         k = (i < 8) ? i : 7;
         applyStimulus(1'b1, 1'b1, 32'h400 + 32'(4*k), 4'hF, 32'hC0DE0000 + 32'(k));
         @(negedge clk);
         checkOutput($sformatf("t4_stall_c%0d", i), 32'(stallreq), (i == 7) ? 32'd1 : 32'd0);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) nextCycle();

      // Two entries left; loads to other words win the port in IDLE
      begin
         logic [31:0] ld_addr [3];
         logic [3:0]  ld_sel  [3];
         logic [31:0] ld_exp  [3];
         ld_addr = '{32'h100, 32'h200, 32'h300};
         ld_sel  = '{4'hF, 4'hC, 4'h1};
         ld_exp  = '{32'h11223344, 32'hAAAA0000, 32'h00000002};
         for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, ld_addr[i], ld_sel[i], 32'h0);
            @(negedge clk);
            checkOutput($sformatf("t5_ld%0d_we", i), 32'(mem_we), 32'd0);
            checkOutput($sformatf("t5_ld%0d_data", i), cpu_rdata, ld_exp[i]);
            checkOutput($sformatf("t5_ld%0d_stall", i), 32'(stallreq), 32'd0);
            nextCycle();
         end
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("t5_resume_we", 32'(mem_we), 32'd1);
      checkOutput("t5_resume_addr", mem_addr, 32'h418);
      for (int i = 0; i < 4; i++) nextCycle();
      checkOutput("t4_log_len", 32'(wlog.size()), 32'd16);
      if (wlog.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t4_log%0d", i), wlog[i][63:32], 32'h400 + 32'(4*(i/2)));
         end
      end

      // Reset during the first BUSY cycle discards all queued stores
      applyStimulus(1'b1, 1'b1, 32'h500, 4'hF, 32'hDEADBEEF);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h504, 4'hF, 32'hCAFEF00D);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
      #1;
      checkOutput("t6_pre_stall", 32'(stallreq), 32'd1);
      rst = 1'b0;
      wlog.delete();
      #1;
      checkOutput("t6_rst_ce", 32'(mem_ce), 32'd0);
      checkOutput("t6_rst_we", 32'(mem_we), 32'd0);
      checkOutput("t6_rst_stall", 32'(stallreq), 32'd0);
      checkOutput("t6_rst_addr", mem_addr, 32'h0);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst = 1'b1;
      nextCycle();
      for (int i = 0; i < 6; i++) nextCycle();
      checkOutput("t6_log_len", 32'(wlog.size()), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h504, 4'hF, 32'h0);
      @(negedge clk);
      checkOutput("t6_no_fwd", cpu_rdata, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
